apb_master: RTL and testbench

- Upstream neighbour of the APB memory slave. Converts a simple valid/ready command stream from a local requester (CPU shim or test driver) into APB SETUP/ACCESS transfers.
- Returns each read/write completion on a one-deep response port.
- Enforces a bounded wait on pready and aborts with an error response on timeout.
- Only one transfer is outstanding at a time.

---
 rtl/apb_pkg.sv | 14 +
 rtl/apb_master.sv | 141 ++++++++++++++
 tb/tb_apb_master.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_pkg.sv
// Shared APB definitions: transfer state encoding and default bus widths.
// Imported by the APB master and the APB memory slave.
package apb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      ACCESS
   } apb_state_t;

   localparam int APB_AW = 8;
   localparam int APB_DW = 32;

endpackage

// File: rtl/apb_master.sv
// APB master: turns a valid/ready command stream into SETUP/ACCESS
// transfers, with a bounded pready wait and a one-deep response register.
module apb_master
   import apb_pkg::*;
#(
   parameter int ADDRWIDTH = APB_AW,
   parameter int DATAWIDTH = APB_DW,
   parameter int TIMEOUT   = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic                 cmd_write,
   input  logic [ADDRWIDTH-1:0] cmd_addr,
   input  logic [DATAWIDTH-1:0] cmd_wdata,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [DATAWIDTH-1:0] rsp_rdata,
   output logic                 rsp_err,
   output logic                 psel,
   output logic                 penable,
   output logic                 pwrite,
   output logic [ADDRWIDTH-1:0] paddr,
   output logic [DATAWIDTH-1:0] pwdata,
   input  logic [DATAWIDTH-1:0] prdata,
   input  logic                 pready,
   input  logic                 pslverr
);

   localparam int CW = $clog2(TIMEOUT);
   localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

   apb_state_t           state_q, state_d;
   logic                 psel_q, psel_d;
   logic                 penable_q, penable_d;
   logic                 pwrite_q, pwrite_d;
   logic [ADDRWIDTH-1:0] paddr_q, paddr_d;
   logic [DATAWIDTH-1:0] pwdata_q, pwdata_d;
   logic                 rsp_valid_q, rsp_valid_d;
   logic                 rsp_err_q, rsp_err_d;
   logic [DATAWIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
   logic [CW-1:0]        wait_q, wait_d;

   assign cmd_ready = (state_q == IDLE) && !rsp_valid_q;
   assign psel      = psel_q;
   assign penable   = penable_q;
   assign pwrite    = pwrite_q;
   assign paddr     = paddr_q;
   assign pwdata    = pwdata_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_err   = rsp_err_q;
   assign rsp_rdata = rsp_rdata_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         psel_q      <= 1'b0;
         penable_q   <= 1'b0;
         pwrite_q    <= 1'b0;
         paddr_q     <= '0;
         pwdata_q    <= '0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= '0;
         wait_q      <= '0;
      end else begin
         state_q     <= state_d;
         psel_q      <= psel_d;
         penable_q   <= penable_d;
         pwrite_q    <= pwrite_d;
         paddr_q     <= paddr_d;
         pwdata_q    <= pwdata_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rsp_rdata_q <= rsp_rdata_d;
         wait_q      <= wait_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      psel_d      = psel_q;
      penable_d   = penable_q;
      pwrite_d    = pwrite_q;
      paddr_d     = paddr_q;
      pwdata_d    = pwdata_q;
      rsp_valid_d = rsp_valid_q;
      rsp_err_d   = rsp_err_q;
      rsp_rdata_d = rsp_rdata_q;
      wait_d      = wait_q;

      // err/rdata keep their value after the handshake; only valid drops
      if (rsp_valid_q && rsp_ready) begin
         rsp_valid_d = 1'b0;
      end

      case (state_q)
         IDLE: begin
            if (cmd_valid && cmd_ready) begin
               pwrite_d  = cmd_write;
               paddr_d   = cmd_addr;
               pwdata_d  = cmd_wdata;
               psel_d    = 1'b1;
               penable_d = 1'b0;
               state_d   = SETUP;
            end
         end
         SETUP: begin
            penable_d = 1'b1;
            wait_d    = '0;
            state_d   = ACCESS;
         end
         ACCESS: begin
            if (pready) begin
               psel_d      = 1'b0;
               penable_d   = 1'b0;
               state_d     = IDLE;
               rsp_valid_d = 1'b1;
               rsp_err_d   = pslverr;
               rsp_rdata_d = (!pwrite_q && !pslverr) ? prdata : '0;
            end else if (wait_q == WAIT_LAST) begin
               psel_d      = 1'b0;
               penable_d   = 1'b0;
               state_d     = IDLE;
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b1;
               rsp_rdata_d = '0;
            end else begin
               wait_d = wait_q + 1'b1;
            end
         end
         default: begin
            psel_d    = 1'b0;
            penable_d = 1'b0;
            state_d   = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master: slave model, response scoreboard and
// per-transfer phase checks.
module tb_apb_master;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [7:0]  cmd_addr;
   logic [31:0] cmd_wdata;
   logic        rsp_valid, rsp_ready, rsp_err;
   logic [31:0] rsp_rdata;
   logic        psel, penable, pwrite;
   logic [7:0]  paddr;
   logic [31:0] pwdata, prdata;
   logic        pready, pslverr;

   typedef struct {
      logic        err;
      logic [31:0] rd;
   } exp_t;

   exp_t        exp_q[$];
   int          passed = 0;
   int          total = 0;

   logic [31:0] mem [256];
   int          slv_waits = 0;
   bit          slv_err = 0;
   bit          slv_hang = 0;
   int          acc_cnt = 0;
   int          last_acc = 0;
   logic [7:0]  acc_a;
   logic [31:0] acc_d;
   logic        acc_w;

   always #5 clk = ~clk;

   apb_master #(
      .ADDRWIDTH (8),
      .DATAWIDTH (32),
      .TIMEOUT   (16)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_write (cmd_write),
      .cmd_addr  (cmd_addr),
      .cmd_wdata (cmd_wdata),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .psel      (psel),
      .penable   (penable),
      .pwrite    (pwrite),
      .paddr     (paddr),
      .pwdata    (pwdata),
      .prdata    (prdata),
      .pready    (pready),
      .pslverr   (pslverr)
   );

   function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h want %0h", nm, act, exp);
   endfunction

   // slave model: drives pready/prdata at negedge, seen at the next posedge
   always @(negedge clk) begin
      if (psel && penable) begin
         if (acc_cnt == 0) begin
            acc_a = paddr;
            acc_d = pwdata;
            acc_w = pwrite;
         end else begin
            chk("paddr_stable", paddr, acc_a);
            chk("pwdata_stable", pwdata, acc_d);
            chk("pwrite_stable", pwrite, acc_w);
         end
         pready  = !slv_hang && (acc_cnt == slv_waits);
         pslverr = pready && slv_err;
         prdata  = slv_err ? 32'h1234 : mem[paddr];
         if (pready && pwrite && !slv_err) mem[paddr] = pwdata;
         acc_cnt++;
      end else begin
         if (acc_cnt != 0) last_acc = acc_cnt;
         acc_cnt = 0;
         pready  = 1'b0;
         pslverr = 1'b0;
         prdata  = 32'h0;
      end
   end

   // scoreboard monitor: one pop per response handshake
   always @(negedge clk) begin
      if (!rst && rsp_valid && rsp_ready) begin
         if (exp_q.size() == 0) begin
            chk("rsp_unexpected", rsp_valid, 1'b0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("rsp_err", rsp_err, e.err);
            chk("rsp_rdata", rsp_rdata, e.rd);
         end
      end
   end

   task automatic issue(input bit wr, input logic [7:0] a,
                        input logic [31:0] d, input int waits,
                        input bit serr, input bit hang, input bit want,
                        input bit exp_err, input logic [31:0] exp_rd);
      int n = 0;
      exp_t e;
      slv_waits = waits;
      slv_err   = serr;
      slv_hang  = hang;
      cmd_write = wr;
      cmd_addr  = a;
      cmd_wdata = d;
      cmd_valid = 1'b1;
      while (!cmd_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("accept_ready", cmd_ready, 1'b1);
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      if (want) begin
         e.err = exp_err;
         e.rd  = exp_rd;
         exp_q.push_back(e);
      end
      @(negedge clk);
      chk("setup_phase", {psel, penable}, 2'b10);
      chk("setup_paddr", paddr, a);
      chk("setup_pwrite", pwrite, wr);
      if (wr) chk("setup_pwdata", pwdata, d);
      @(negedge clk);
      chk("access_phase", {psel, penable}, 2'b11);
   endtask

   task automatic wait_done(input int exp_acc);
      int n = 0;
      while (!rsp_valid && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk("rsp_seen", rsp_valid, 1'b1);
      chk("psel_idle", psel, 1'b0);
      @(negedge clk);
      chk("acc_cycles", last_acc, exp_acc);
      chk("cmd_ready_back", cmd_ready, 1'b1);
   endtask

   initial begin
      int n;
      for (int i = 0; i < 256; i++) mem[i] = 32'h0;
      rst = 1'b1;
      cmd_valid = 1'b0;
      cmd_write = 1'b0;
      cmd_addr  = 8'h0;
      cmd_wdata = 32'h0;
      rsp_ready = 1'b1;
      pready = 1'b0;
      pslverr = 1'b0;
      prdata = 32'h0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_apb", {psel, penable, pwrite}, 3'b000);
      chk("rst_rsp", {rsp_valid, rsp_err}, 2'b00);
      chk("rst_paddr", paddr, 8'h0);
      chk("rst_pwdata", pwdata, 32'h0);
      chk("rst_rdata", rsp_rdata, 32'h0);
      chk("rst_cmd_ready", cmd_ready, 1'b1);

      // write, zero wait states
      issue(1, 8'h10, 32'hDEADBEEF, 0, 0, 0, 1, 0, 32'h0);
      wait_done(1);
      // read back with 3 wait states
      issue(0, 8'h10, 32'h0, 3, 0, 0, 1, 0, 32'hDEADBEEF);
      wait_done(4);
      // timeout
      issue(0, 8'h20, 32'h0, 0, 0, 1, 1, 1, 32'h0);
      wait_done(16);

      // response backpressure with the next command pending
      rsp_ready = 1'b0;
      issue(0, 8'h10, 32'h0, 1, 0, 0, 1, 0, 32'hDEADBEEF);
      n = 0;
      while (!rsp_valid && n < 300) begin
         @(negedge clk);
         n++;
      end
      slv_waits = 0;
      slv_err   = 0;
      slv_hang  = 0;
      cmd_write = 1'b1;
      cmd_addr  = 8'h40;
      cmd_wdata = 32'hCAFEF00D;
      cmd_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         chk("bp_cmd_ready", cmd_ready, 1'b0);
         chk("bp_rsp_valid", rsp_valid, 1'b1);
         chk("bp_rsp_rdata", rsp_rdata, 32'hDEADBEEF);
         chk("bp_rsp_err", rsp_err, 1'b0);
         @(negedge clk);
      end
      @(posedge clk);
      #1 rsp_ready = 1'b1;
      @(negedge clk);
      chk("bp_pre_hs", cmd_ready, 1'b0);
      @(posedge clk);
      #1 chk("bp_post_hs", cmd_ready, 1'b1);
      issue(1, 8'h40, 32'hCAFEF00D, 0, 0, 0, 1, 0, 32'h0);
      wait_done(1);
      issue(0, 8'h40, 32'h0, 2, 0, 0, 1, 0, 32'hCAFEF00D);
      wait_done(3);

      // slave error on a read
      issue(0, 8'h30, 32'h0, 0, 1, 0, 1, 1, 32'h0);
      wait_done(1);

      // reset during ACCESS of a write: no response expected
      issue(1, 8'h50, 32'h11111111, 0, 0, 1, 0, 0, 32'h0);
      repeat (3) @(negedge clk);
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      chk("rstmid_apb", {psel, penable}, 2'b00);
      chk("rstmid_rsp", rsp_valid, 1'b0);
      chk("rstmid_idle", cmd_ready, 1'b1);
      chk("rstmid_paddr", paddr, 8'h0);
      repeat (20) @(negedge clk);
      chk("rstmid_no_rsp", rsp_valid, 1'b0);
      issue(1, 8'h50, 32'h0BADCAFE, 0, 0, 0, 1, 0, 32'h0);
      wait_done(1);
      issue(0, 8'h50, 32'h0, 1, 0, 0, 1, 0, 32'h0BADCAFE);
      wait_done(2);

      repeat (4) @(negedge clk);
      chk("queue_empty", exp_q.size(), 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
